// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencing and M:SS.T BCD accumulation of base_tick pulses
module stopwatch_ctrl #(
    parameter int MAX_MIN = 9
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    input  logic       base_tick,
    output logic       timer_enb,
    output logic       running,
    output logic       lap_active,
    output logic       overflow,
    output logic [3:0] disp_tenths,
    output logic [3:0] disp_sec_ones,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_min
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_MIN);

    state_t      r_state;
    state_t      w_next;
    logic        r_timer_enb;
    logic        r_running;
    logic        r_lap_active;
    logic        r_overflow;
    logic [3:0]  r_t;
    logic [3:0]  r_so;
    logic [3:0]  r_st;
    logic [3:0]  r_m;
    logic [15:0] r_snap;
    logic [15:0] w_live;
    logic [15:0] w_disp;
    logic        w_tick;
    logic        w_clr;
    logic        w_c0;
    logic        w_c1;
    logic        w_c2;
    logic        w_wrap;

    // Clear beats start_stop, which beats lap; an illegal pulse never masks a lower one
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (start_stop && !clear) ? RUN : IDLE;
            RUN:     w_next = start_stop ? PAUSE : (lap ? LAP : RUN);
            LAP:     w_next = start_stop ? PAUSE : (lap ? RUN : LAP);
            PAUSE:   w_next = clear ? IDLE : (start_stop ? RUN : PAUSE);
            default: w_next = IDLE;
        endcase
    end

    assign w_clr  = clear && (r_state == IDLE || r_state == PAUSE);
    assign w_tick = base_tick && r_timer_enb;
    assign w_c0   = w_tick && r_t == 4'd9;
    assign w_c1   = w_c0 && r_so == 4'd9;
    assign w_c2   = w_c1 && r_st == 4'd5;
    assign w_wrap = w_c2 && r_m == LP_MAX;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_timer_enb  <= 1'b0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer_enb  <= w_next == RUN || w_next == LAP;
            r_running    <= w_next == RUN || w_next == LAP;
            r_lap_active <= w_next == LAP;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t        <= 4'd0;
            r_so       <= 4'd0;
            r_st       <= 4'd0;
            r_m        <= 4'd0;
            r_overflow <= 1'b0;
        end else if (w_clr) begin
            r_t        <= 4'd0;
            r_so       <= 4'd0;
            r_st       <= 4'd0;
            r_m        <= 4'd0;
            r_overflow <= 1'b0;
        end else if (w_tick) begin
            r_t <= w_c0 ? 4'd0 : r_t + 4'd1;
            if (w_c0) r_so <= w_c1 ? 4'd0 : r_so + 4'd1;
            if (w_c1) r_st <= w_c2 ? 4'd0 : r_st + 4'd1;
            if (w_c2) r_m <= w_wrap ? 4'd0 : r_m + 4'd1;
            if (w_wrap) r_overflow <= 1'b1;
        end
    end

    // Snapshot takes the pre-increment count even if a tick lands on the lap edge
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) r_snap <= 16'h0;
        else if (r_state == RUN && w_next == LAP) r_snap <= w_live;
    end

    assign w_live        = {r_m, r_st, r_so, r_t};
    assign w_disp        = (r_state == LAP) ? r_snap : w_live;
    assign disp_min      = w_disp[15:12];
    assign disp_sec_tens = w_disp[11:8];
    assign disp_sec_ones = w_disp[7:4];
    assign disp_tenths   = w_disp[3:0];
    assign timer_enb     = r_timer_enb;
    assign running       = r_running;
    assign lap_active    = r_lap_active;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed test-plan sequences plus random pulses against a tenths-count reference model
module tb_stopwatch_ctrl;
    localparam int MAX_MIN = 9;
    localparam int LIMIT   = (MAX_MIN + 1) * 600;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic       base_tick = 1'b0;
    logic       timer_enb;
    logic       running;
    logic       lap_active;
    logic       overflow;
    logic [3:0] disp_tenths;
    logic [3:0] disp_sec_ones;
    logic [3:0] disp_sec_tens;
    logic [3:0] disp_min;

    int n_vec = 0;
    int n_err = 0;

    // Reference: elapsed time as a plain tenths count; IDLE and PAUSE look identical from outside
    int m_cnt;
    int m_snap;
    bit m_run;
    bit m_lap;
    bit m_ovf;

    stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .start_stop   (start_stop),
        .clear        (clear),
        .lap          (lap),
        .base_tick    (base_tick),
        .timer_enb    (timer_enb),
        .running      (running),
        .lap_active   (lap_active),
        .overflow     (overflow),
        .disp_tenths  (disp_tenths),
        .disp_sec_ones(disp_sec_ones),
        .disp_sec_tens(disp_sec_tens),
        .disp_min     (disp_min)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] bcd(input int c);
        return {4'(c / 600), 4'((c / 100) % 6), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("disp", {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths}, m_lap ? bcd(m_snap) : bcd(m_cnt));
        chk("timer_enb", 16'(timer_enb), 16'(m_run));
        chk("running", 16'(running), 16'(m_run));
        chk("lap_active", 16'(lap_active), 16'(m_lap));
        chk("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_snap = 0;
        m_run  = 0;
        m_lap  = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp, input bit tk);
        bit counted;
        counted = tk && m_run;
        if (cl && !m_run) begin
            m_cnt = 0;
            m_ovf = 0;
        end else if (ss) begin
            m_lap = 0;
            m_run = !m_run;
        end else if (lp && m_run) begin
            if (!m_lap) m_snap = m_cnt;
            m_lap = !m_lap;
        end
        if (counted) begin
            m_cnt++;
            if (m_cnt == LIMIT) begin
                m_cnt = 0;
                m_ovf = 1;
            end
        end
    endtask

    task automatic step(input bit ss, input bit cl, input bit lp, input bit tk);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        base_tick  = tk;
        @(posedge sys_clk);
        model_step(ss, cl, lp, tk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        base_tick  = 1'b0;
        chk_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge sys_clk);
        #1;
        chk_all();
        reset_n = 1'b1;
    endtask

    logic [15:0] w_disp_now;
    assign w_disp_now = {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths};

    initial begin
        model_reset();
        #2;
        chk("reset_disp", w_disp_now, 16'h0000);
        chk("reset_enb", 16'(timer_enb), 16'h0);
        @(posedge sys_clk);
        #1;
        reset_n = 1'b1;

        // Basic count
        step(1, 0, 0, 0);
        chk("start_enb", 16'(timer_enb), 16'h1);
        ticks(125);
        chk("basic", w_disp_now, 16'h0125);

        // Pause and resume
        do_reset();
        step(1, 0, 0, 0);
        ticks(37);
        step(1, 0, 0, 0);
        ticks(20);
        chk("pause_hold", w_disp_now, 16'h0037);
        chk("pause_enb", 16'(timer_enb), 16'h0);
        step(1, 0, 0, 0);
        ticks(3);
        chk("resume", w_disp_now, 16'h0040);

        // Lap freeze and release
        do_reset();
        step(1, 0, 0, 0);
        ticks(50);
        step(0, 0, 1, 0);
        ticks(30);
        chk("lap_frozen", w_disp_now, 16'h0050);
        chk("lap_active", 16'(lap_active), 16'h1);
        step(0, 0, 1, 0);
        chk("lap_release", w_disp_now, 16'h0080);

        // Wrap and overflow
        do_reset();
        step(1, 0, 0, 0);
        ticks(5999);
        chk("max", w_disp_now, 16'h9599);
        chk("ovf_before", 16'(overflow), 16'h0);
        ticks(1);
        chk("wrap", w_disp_now, 16'h0000);
        chk("ovf_set", 16'(overflow), 16'h1);
        ticks(7);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("ovf_clear", 16'(overflow), 16'h0);

        // Clear gating
        do_reset();
        step(1, 0, 0, 0);
        ticks(20);
        step(0, 1, 0, 0);
        chk("clr_in_run", w_disp_now, 16'h0020);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("clr_ss_disp", w_disp_now, 16'h0000);
        chk("clr_ss_enb", 16'(timer_enb), 16'h0);

        // Coincident tick with lap / start_stop
        do_reset();
        step(1, 0, 0, 0);
        ticks(9);
        step(0, 0, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        ticks(4);

        // Asynchronous reset between edges
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_disp", w_disp_now, 16'h0000);
        chk("async_run", 16'(running), 16'h0);
        chk_all();
        @(posedge sys_clk);
        #1;
        reset_n = 1'b1;

        // Random pulses
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
